// File: rtl/sonic_ranger_multi.sv
// Round-robin ultrasonic ranger: one HC-SR04-class sensor is triggered per slot. The echo width is
// timed in microsecond ticks, divided down to centimetres, and used to drive per-channel stop flags.
module sonic_ranger_multi #(
    parameter int CLK_HZ     = 100000000,
    parameter int N_CH       = 2,
    parameter int SLOT_MS    = 100,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int DIST_W     = 10,
    parameter int STOP_CM    = 40,
    parameter int HYST_CM    = 5,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   echo,
    output logic [N_CH-1:0]   trig,
    output logic              dist_valid,
    output logic [CH_W-1:0]   dist_ch,
    output logic [DIST_W-1:0] dist_cm,
    output logic              dist_timeout,
    output logic [N_CH-1:0]   stop,
    output logic              stop_any
);

    localparam int PRE_N    = CLK_HZ / 1000000;
    localparam int PRE_W    = $clog2(PRE_N);
    localparam int SLOT_N   = SLOT_MS * 1000;
    localparam int SLOT_W   = $clog2(SLOT_N);
    localparam int CNT_W    = $clog2(TIMEOUT_US + 1);
    localparam int TRIG_W   = $clog2(TRIG_US + 1);
    localparam int DIST_MAX = (1 << DIST_W) - 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRE_N - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_N - 1);
    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0]  TO_CNT    = CNT_W'(TIMEOUT_US);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0]  CM_DIV    = CNT_W'(58);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DIVIDE, DONE, GAP} state_t;

    state_t            state;
    logic [PRE_W-1:0]  pre;
    logic              tick;
    logic [SLOT_W-1:0] slot;
    logic              wrap;
    logic [CH_W-1:0]   ch;
    logic [CH_W-1:0]   next_ch;
    logic [TRIG_W-1:0] trig_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  q;
    logic              to_flag;
    logic [N_CH-1:0]   sync1, sync2;
    logic              echo_act, rise, fall;
    logic [N_CH-1:0]   trig_sel;
    logic [DIST_W-1:0] res_cm;

    function automatic logic [DIST_W-1:0] sat_dist(input logic [CNT_W-1:0] v);
        if (32'(v) > DIST_MAX)
            return DIST_W'(DIST_MAX);
        return DIST_W'(v);
    endfunction

    assign tick     = (pre == PRE_LAST);
    assign wrap     = tick && (slot == SLOT_LAST);
    assign next_ch  = (ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;
    assign echo_act = sync1[ch];
    assign rise     = sync1[ch] & ~sync2[ch];
    assign fall     = ~sync1[ch] & sync2[ch];
    assign res_cm   = to_flag ? DIST_W'(DIST_MAX) : sat_dist(q);

    always_comb begin
        trig_sel = '0;
        for (int i = 0; i < N_CH; i++)
            trig_sel[i] = (ch == CH_W'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre   <= '0;
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            pre   <= tick ? '0 : pre + 1'b1;
            sync1 <= echo;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            slot         <= '0;
            ch           <= '0;
            trig         <= '0;
            trig_cnt     <= '0;
            cnt          <= '0;
            to_flag      <= 1'b0;
            dist_valid   <= 1'b0;
            dist_ch      <= '0;
            dist_cm      <= '0;
            dist_timeout <= 1'b0;
            stop         <= '0;
            stop_any     <= 1'b0;
        end else begin
            dist_valid <= 1'b0;
            stop_any   <= |stop;
            if (tick)
                slot <= wrap ? '0 : slot + 1'b1;
            // The slot boundary overrides every state so each channel gets exactly one slot.
            if (wrap) begin
                state <= IDLE;
                trig  <= '0;
                ch    <= next_ch;
            end else begin
                case (state)
                    IDLE: if (tick) begin
                        state    <= TRIG;
                        trig     <= trig_sel;
                        trig_cnt <= '0;
                    end
                    TRIG: if (tick) begin
                        if (trig_cnt == TRIG_LAST) begin
                            trig    <= '0;
                            cnt     <= '0;
                            to_flag <= 1'b0;
                            state   <= WAIT_RISE;
                        end else begin
                            trig_cnt <= trig_cnt + 1'b1;
                        end
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            cnt   <= '0;
                            state <= MEASURE;
                        end else if (tick) begin
                            if (cnt == TO_LAST) begin
                                to_flag <= 1'b1;
                                state   <= DONE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    MEASURE: begin
                        // Checking the limit before the fall lets the timeout win a same-clk tie.
                        if (cnt == TO_CNT) begin
                            to_flag <= 1'b1;
                            state   <= DONE;
                        end else if (fall) begin
                            state <= DIVIDE;
                        end else if (tick && echo_act) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DIVIDE: if (rem < CM_DIV) state <= DONE;
                    DONE: begin
                        dist_valid   <= 1'b1;
                        dist_ch      <= ch;
                        dist_cm      <= res_cm;
                        dist_timeout <= to_flag;
                        if (!to_flag && 32'(res_cm) < STOP_CM)
                            stop[ch] <= 1'b1;
                        else if (to_flag || 32'(res_cm) >= STOP_CM + HYST_CM)
                            stop[ch] <= 1'b0;
                        state <= GAP;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Restoring divider by 58 us/cm; the operand is reloaded every clk spent in MEASURE.
    always_ff @(posedge clk) begin
        if (state == MEASURE) begin
            rem <= cnt;
            q   <= '0;
        end else if (state == DIVIDE && rem >= CM_DIV) begin
            rem <= rem - CM_DIV;
            q   <= q + 1'b1;
        end
    end

endmodule

// File: tb/tb_sonic_ranger_multi.sv
// Randomised slot-by-slot bench for sonic_ranger_multi, with a small behavioural model of
// distance, timeout and stop hysteresis. The geometry is scaled down to keep runs short.
module tb_sonic_ranger_multi;

    localparam int CLK_HZ     = 2000000;
    localparam int N_CH       = 2;
    localparam int SLOT_MS    = 3;
    localparam int TRIG_US    = 10;
    localparam int TIMEOUT_US = 900;
    localparam int DIST_W     = 3;
    localparam int STOP_CM    = 4;
    localparam int HYST_CM    = 2;
    localparam int CH_W       = 1;
    localparam int DMAX       = (1 << DIST_W) - 1;
    localparam int SLOT_CLKS  = SLOT_MS * 1000 * 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_CH-1:0]   echo;
    logic [N_CH-1:0]   trig;
    logic              dist_valid;
    logic [CH_W-1:0]   dist_ch;
    logic [DIST_W-1:0] dist_cm;
    logic              dist_timeout;
    logic [N_CH-1:0]   stop;
    logic              stop_any;

    sonic_ranger_multi #(
        .CLK_HZ(CLK_HZ), .N_CH(N_CH), .SLOT_MS(SLOT_MS), .TRIG_US(TRIG_US),
        .TIMEOUT_US(TIMEOUT_US), .DIST_W(DIST_W), .STOP_CM(STOP_CM), .HYST_CM(HYST_CM)
    ) dut (
        .clk(clk), .rst(rst), .echo(echo), .trig(trig), .dist_valid(dist_valid),
        .dist_ch(dist_ch), .dist_cm(dist_cm), .dist_timeout(dist_timeout),
        .stop(stop), .stop_any(stop_any)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit [N_CH-1:0] stop_m = '0;

    int            nvalid = 0;
    int            onehot_bad = 0;
    int            cap_ch, cap_cm, cap_to, cap_stop_any;
    logic [N_CH-1:0] cap_stop;
    bit            pend = 1'b0;

    always @(negedge clk) begin
        if (pend) begin
            cap_stop_any <= int'(stop_any);
            pend <= 1'b0;
        end
        if (dist_valid) begin
            cap_ch   <= int'(dist_ch);
            cap_cm   <= int'(dist_cm);
            cap_to   <= int'(dist_timeout);
            cap_stop <= stop;
            nvalid   <= nvalid + 1;
            pend     <= 1'b1;
        end
        if ($countones(trig) > 1)
            onehot_bad <= onehot_bad + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_result(input int mode, input int w_us, output int to, output int cm);
        if (mode == 0 || w_us >= TIMEOUT_US) begin
            to = 1;
            cm = DMAX;
        end else begin
            to = 0;
            cm = (w_us / 58 > DMAX) ? DMAX : w_us / 58;
        end
    endtask

    task automatic idle_us(input int us);
        repeat (2 * us) @(negedge clk);
    endtask

    // mode 0: no echo; mode 1: echo pulse of w_us starting d_us after trig falls
    task automatic run_slot(input int ch, input int mode, input int d_us, input int w_us,
                            input bit tog, input int exp_lat);
        int waited, width, base, to, cm, o;
        o = (ch + 1) % N_CH;
        waited = 0;
        while (trig == '0 && waited < 2 * SLOT_CLKS) begin
            @(negedge clk);
            waited++;
        end
        chk("trig_onehot", int'(trig), 1 << ch);
        if (exp_lat >= 0)
            chk("first_trig_lat", waited, exp_lat);
        width = 0;
        while (trig != '0 && width < 1000) begin
            width++;
            @(negedge clk);
        end
        chk("trig_width", width, 2 * TRIG_US);

        model_result(mode, w_us, to, cm);
        if (to == 0 && cm < STOP_CM)
            stop_m[ch] = 1'b1;
        else if (to == 1 || cm >= STOP_CM + HYST_CM)
            stop_m[ch] = 1'b0;

        base = nvalid;
        echo[o] = tog;
        idle_us(3);
        echo[o] = 1'b0;
        idle_us(d_us);
        if (mode == 1) begin
            echo[ch] = 1'b1;
            idle_us(w_us / 2);
            echo[o] = tog;
            idle_us(2);
            echo[o] = 1'b0;
            idle_us(w_us - w_us / 2 - 2);
            echo[ch] = 1'b0;
        end
        waited = 0;
        while (nvalid == base && waited < 4 * TIMEOUT_US + 400) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("valid_seen", int'(nvalid != base), 1);
        chk("dist_ch", cap_ch, ch);
        chk("dist_cm", cap_cm, cm);
        chk("dist_timeout", cap_to, to);
        chk("stop_vec", int'(cap_stop), int'(stop_m));
        repeat (2) @(negedge clk);
        #1;
        chk("stop_any", cap_stop_any, int'(|stop_m));
        chk("valid_count", nvalid - base, 1);
    endtask

    task automatic abort_slot();
        int waited, base;
        waited = 0;
        while (trig == '0 && waited < 2 * SLOT_CLKS) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_slot_ch", int'(trig), 1);
        idle_us(TRIG_US + 50);
        echo[0] = 1'b1;
        idle_us(100);
        #1;
        base = nvalid;
        #2 rst = 1'b1;
        #1;
        chk("abort_trig", int'(trig), 0);
        chk("abort_stop", int'(stop), 0);
        chk("abort_stop_any", int'(stop_any), 0);
        chk("abort_valid", int'(dist_valid), 0);
        stop_m = '0;
        @(negedge clk);
        echo[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_no_result", nvalid - base, 0);
        chk("abort_post_trig", int'(trig), 0);
    endtask

    function automatic int pulse_us(input int cm);
        return 58 * cm + int'($urandom_range(10, 45));
    endfunction

    initial begin
        int mode, w;
        rst  = 1'b1;
        echo = '0;
        repeat (3) @(negedge clk);
        chk("rst_trig", int'(trig), 0);
        chk("rst_valid", int'(dist_valid), 0);
        chk("rst_cm", int'(dist_cm), 0);
        chk("rst_stop", int'(stop), 0);
        chk("rst_stop_any", int'(stop_any), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_trig", int'(trig), 0);
        chk("post_rst_valid", int'(dist_valid), 0);

        run_slot(0, 1, $urandom_range(5, 300), pulse_us(1), 1'($urandom), 1); // near: sets stop[0]
        run_slot(1, 0, 0, 0, 1'($urandom), -1);                               // no echo
        run_slot(0, 1, $urandom_range(5, 300), pulse_us(4), 1'($urandom), -1); // hold band
        run_slot(1, 1, $urandom_range(5, 300), TIMEOUT_US + 60, 1'b1, -1);    // echo too long
        run_slot(0, 1, $urandom_range(5, 300), pulse_us(5), 1'($urandom), -1); // still holds
        run_slot(1, 1, $urandom_range(5, 300), pulse_us(2), 1'($urandom), -1);
        run_slot(0, 1, $urandom_range(5, 300), pulse_us(6), 1'($urandom), -1); // release
        run_slot(1, 1, $urandom_range(5, 300), pulse_us(3), 1'($urandom), -1);
        run_slot(0, 1, $urandom_range(5, 300), pulse_us(3), 1'($urandom), -1); // sets again
        run_slot(1, 1, $urandom_range(5, 300), pulse_us(12), 1'($urandom), -1); // saturates
        abort_slot();
        run_slot(0, 1, $urandom_range(5, 300), pulse_us(0), 1'($urandom), 1);  // zero distance
        mode = int'($urandom_range(0, 2));
        w = (mode == 2) ? TIMEOUT_US + int'($urandom_range(20, 60))
                        : pulse_us(int'($urandom_range(0, 14)));
        run_slot(1, (mode == 0) ? 0 : 1, $urandom_range(5, 300), w, 1'($urandom), -1);

        chk("trig_onehot_viol", onehot_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sonic_ranger_multi.md
Name: sonic_ranger_multi

Overview:
- Parametrised multi-channel ultrasonic ranger for HC-SR04-class sensors.
- Fires N_CH sensors round-robin, one per slot, so that echoes cannot crosstalk.
- Measures each echo pulse against an internal 1 us tick, converts it to centimetres with a sequential divider, and reports one result per slot.
- Drives per-channel stop flags with hysteresis. Sits between the sensor pins and the motor/LED control logic.

Parameters:
CLK_HZ, 100000000, system clock frequency; CLK_HZ/1000000 must be an integer >= 2
N_CH, 2, number of sensor channels (1..8)
SLOT_MS, 100, length of one channel slot in ms; each sensor is retriggered every N_CH*SLOT_MS
TRIG_US, 10, trigger pulse width in us
TIMEOUT_US, 30000, maximum wait for echo rise, and maximum echo high time, in us
DIST_W, 10, width of the distance result in cm
STOP_CM, 40, stop set threshold in cm
HYST_CM, 5, stop release margin in cm
Constraint: SLOT_MS*1000 > TRIG_US + 2*TIMEOUT_US + 1000

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
echo  in  N_CH  raw echo inputs, asynchronous to clk
trig  out  N_CH  trigger outputs; at most one bit high at a time
dist_valid  out  1  one-clk pulse when a result is presented
dist_ch  out  CH_W  channel of the current result; CH_W = max(1, clog2(N_CH))
dist_cm  out  DIST_W  distance in cm, held until the next dist_valid
dist_timeout  out  1  qualifies dist_valid: no echo, or echo too long
stop  out  N_CH  per-channel obstacle-near flags
stop_any  out  1  OR of stop

Behaviour:
- Reset (async, active-high): all outputs 0, FSM in IDLE, active channel 0, all counters 0, echo synchronisers 0. A reset asserted mid-slot aborts the slot immediately, with no result.
- Tick: a free-running prescaler counts 0..CLK_HZ/1e6-1 and emits a one-clk tick at wrap. No derived clocks; all logic runs on clk.
- Echo path: every echo bit passes a 2-FF synchroniser. A rising edge is sync1 & ~sync2; a falling edge is ~sync1 & sync2. Only the active channel is observed; all others are ignored.
- Slot counter: counts ticks from 0 to SLOT_MS*1000-1. On wrap, the FSM returns to IDLE and ch advances as ch+1 mod N_CH.
- FSM states:
  - IDLE: on the first tick, go to TRIG and raise trig[ch].
  - TRIG: hold trig[ch] high for exactly TRIG_US ticks, then drop it and go to WAIT_RISE with the wait counter cleared.
  - WAIT_RISE: on a rising edge, go to MEASURE with cnt=0. An echo already high on entry does not count as a rise. If TIMEOUT_US ticks pass first, go to DONE with the timeout flag set.
  - MEASURE: cnt increments on each tick while synchronised echo is high. On a falling edge, go to DIVIDE. If cnt reaches TIMEOUT_US, go to DONE with the timeout flag set.
  - DIVIDE: restoring division by 58, one subtraction per clk. While rem >= 58: rem -= 58 and q += 1. Then go to DONE.
  - DONE: assert dist_valid for one clk, with dist_ch=ch and dist_timeout set per the flag. dist_cm = q saturated to 2^DIST_W-1; on timeout, dist_cm = 2^DIST_W-1. Then go to GAP.
  - GAP: wait for the slot counter to wrap.
- Stop flags, updated in the same clk as dist_valid for channel ch only:
  - set stop[ch] if the result is not a timeout and dist_cm < STOP_CM;
  - clear stop[ch] if dist_cm >= STOP_CM+HYST_CM or on timeout;
  - otherwise hold.
- stop_any is registered OR of the stop bits, one clk after a stop change.
- Result latency: dist_valid rises floor(cnt/58)+2 clks after the DIVIDE entry clk.
- Edge cases:
  - A rise and a timeout on the same tick: the rise wins.
  - A fall on the same clk as cnt reaches TIMEOUT_US: the timeout wins.
  - cnt=0 (fall on the first sample) gives dist_cm=0, which sets stop.

Test Plan:
- Bench override CLK_HZ=2000000, N_CH=2, SLOT_MS=70. After reset release -> trig[0] high for exactly 20 clks, starting on the first tick; trig[1] low; all outputs 0 before that.
- echo[0] high for 1160 us, 100 us after trig falls -> dist_valid with dist_ch=0, dist_cm=20, dist_timeout=0; stop[0]=1; stop_any=1 one clk later.
- Hysteresis on ch0: echoes giving 42 cm, then 45 cm -> stop[0] stays 1 after 42 and clears after 45. A following 39 cm result sets it again.
- echo[1] never rises -> after 30000 us, dist_valid with dist_ch=1, dist_timeout=1, dist_cm=1023; stop[1] cleared.
- echo[1] held high for 40000 us and echo[0] toggled during ch1's slot -> timeout reported on ch1; the ch0 toggles produce no result and no stop change.
- Assert rst in the middle of MEASURE on ch0 -> trig=0 and stop=0 immediately. After release, the next trigger is on ch0 and there is no dist_valid from the aborted slot.
